// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo: circular byte FIFO that feeds UART_TX one byte at a time.
// Ports:
//   i_CLK, i_RESET       clock, async active-high reset
//   i_WR_EN, i_WR_DATA   host write port, one byte per cycle
//   o_FULL, o_EMPTY      FIFO occupancy flags
//   o_COUNT              stored bytes (excludes the byte handed to UART_TX)
//   o_OVERFLOW           one-cycle pulse after a dropped write
//   o_IDLE               nothing stored and nothing in flight
//   o_tx_DATA_READY      request to UART_TX
//   o_tx_DATA            registered byte to UART_TX
//   i_tx_BUSY, i_tx_DONE status from UART_TX
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic              i_WR_EN,
  input  logic [7:0]        i_WR_DATA,
  output logic              o_FULL,
  output logic              o_EMPTY,
  output logic [ADDR_W:0]   o_COUNT,
  output logic              o_OVERFLOW,
  output logic              o_IDLE,
  output logic              o_tx_DATA_READY,
  output logic [7:0]        o_tx_DATA,
  input  logic              i_tx_BUSY,
  input  logic              i_tx_DONE
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  state_t            state_q;
  state_t            state_d;
  logic              dr_q;
  logic              dr_d;
  logic [7:0]        data_q;
  logic              ovf_q;
  logic              pop;
  logic              full_now;
  logic              wr_acc;

  // Fullness is judged on the pre-edge count, so a write
  // while full is dropped even if a pop frees a slot.
  assign full_now = (count_q == FULL_CNT);
  assign wr_acc   = i_WR_EN && !full_now;

  always_comb begin
    state_d = state_q;
    dr_d    = dr_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0 && !i_tx_BUSY) begin
          pop     = 1'b1;
          dr_d    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_tx_BUSY) begin
          dr_d    = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_tx_DONE || !i_tx_BUSY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        dr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= IDLE;
      dr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dr_q    <= dr_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (wr_acc) begin
      mem[wr_ptr] <= i_WR_DATA;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= i_WR_EN && full_now;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        data_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({wr_acc, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_FULL          = full_now;
  assign o_EMPTY         = (count_q == '0);
  assign o_COUNT         = count_q;
  assign o_OVERFLOW      = ovf_q;
  assign o_IDLE          = (state_q == IDLE) && (count_q == '0);
  assign o_tx_DATA_READY = dr_q;
  assign o_tx_DATA       = data_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and feeder directly upstream of UART_TX. Accepts bytes from a host-side write port in single-cycle writes and stores them in a circular FIFO. Hands bytes one at a time to UART_TX over its data-ready / busy / done handshake, so the host can queue a burst without tracking serial timing.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two, 2..256.
ADDR_W, 4, log2(DEPTH); pointer width; must be set consistently with DEPTH.

Ports:
i_CLK  input  1  system clock (25 MHz nominal).
i_RESET  input  1  asynchronous, active-high reset.
i_WR_EN  input  1  host write strobe; one byte per cycle when high.
i_WR_DATA  input  8  host byte.
o_FULL  output  1  FIFO holds DEPTH entries.
o_EMPTY  output  1  FIFO holds 0 entries.
o_COUNT  output  ADDR_W+1  stored entries; excludes the byte handed to UART_TX.
o_OVERFLOW  output  1  one-cycle pulse when a write is dropped.
o_IDLE  output  1  FSM in IDLE and FIFO empty, i.e. nothing pending or in flight.
o_tx_DATA_READY  output  1  to UART_TX i_tx_DATA_READY.
o_tx_DATA  output  8  to UART_TX i_tx_DATA; registered.
i_tx_BUSY  input  1  from UART_TX o_tx_BUSY.
i_tx_DONE  input  1  from UART_TX o_tx_DONE.

Behaviour:
- Reset (async assert, sync release): rd/wr pointers 0, count 0, FSM IDLE, o_tx_DATA_READY 0, o_tx_DATA 8'h00, o_OVERFLOW 0, o_FULL 0, o_EMPTY 1, o_IDLE 1. Reset mid-operation discards all stored bytes and drops DATA_READY immediately. No attempt is made to abort a frame already inside UART_TX.
- Storage: DEPTH x 8 array; pointers wrap modulo DEPTH; count is a separate ADDR_W+1-bit register.
- Write:
  - If i_WR_EN=1 and count<DEPTH at the edge: store at wr_ptr, wr_ptr+1, count+1.
  - If count==DEPTH: the byte is dropped and o_OVERFLOW=1 for the next cycle. Fullness uses the pre-edge count, so a write while full is dropped even if a pop occurs on the same edge.
- Pop: occurs only on the IDLE->REQ transition. o_tx_DATA<=mem[rd_ptr], rd_ptr+1, count-1.
- Simultaneous write and pop: the count is unchanged and both pointers advance.
- Write to an empty FIFO: the pop cannot occur on the same edge. The byte written at edge k is popped at edge k+1, and o_tx_DATA_READY is high after edge k+1.
- FSM:
  - IDLE: if count!=0 and i_tx_BUSY=0, pop, set DATA_READY<=1, go to REQ. Otherwise stay.
  - REQ: hold DATA_READY=1 and o_tx_DATA stable until i_tx_BUSY=1 is sampled, then DATA_READY<=0 and go to WAIT_DONE. There is no timeout; the block waits indefinitely.
  - WAIT_DONE: on i_tx_DONE=1 or i_tx_BUSY=0, go to IDLE. Otherwise stay.
- Back-to-back throughput: one cycle minimum in IDLE between frames. The next DATA_READY rises the cycle after the DONE/busy-low is sampled.
- o_tx_DATA changes only on a pop. It holds its last value otherwise.
- o_FULL, o_EMPTY, o_IDLE and o_COUNT are decoded from the registered count and state; no combinational path from the inputs.

Test Plan:
- Reset: assert i_RESET 2 cycles mid-run -> o_EMPTY=1, o_FULL=0, o_COUNT=0, o_tx_DATA_READY=0, o_tx_DATA=8'h00, o_IDLE=1.
- Single byte, looped through UART_TX->UART_RX: write 8'h31 -> DATA_READY rises 1 cycle after the write, o_tx_DATA=8'h31 until BUSY rises, then DATA_READY=0 -> UART_RX o_DATA_READY pulse with o_RX_DATA=8'h31 -> o_IDLE=1 after DONE.
- Burst, looped: write 8'h31,8'hff,8'h4a,8'h01,8'h2d on 5 consecutive cycles -> o_COUNT peaks at 4 -> UART_RX delivers the same 5 bytes in order, no gaps beyond 1 IDLE cycle.
- Overflow, standalone with a UART_TX model holding BUSY=0 and never accepting: write 18 bytes -> first byte parked in REQ, o_COUNT=16, o_FULL=1, 18th dropped with a single o_OVERFLOW pulse. Then release the model -> bytes 1..17 emitted in order.
- Full plus simultaneous pop: at count=DEPTH in IDLE with the model ready, write on the pop edge -> write dropped, o_OVERFLOW pulses, o_COUNT=15 after the edge.
- Wrap-around, looped: stream 40 bytes 8'h00..8'h27 with random write gaps -> all 40 received in order, o_OVERFLOW never asserted.
